// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave with programmable wait states, byte/halfword
// lanes and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]            state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            strb, strb_q;
    logic                  write_q;
    logic                  active_q;
    logic                  accept;
    logic                  xfer_err;
    logic                  commit;
    logic [31:0]           wmask;
    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
    logic                  unused_ok;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning here: every beat is decoded alone.
    assign unused_ok = ^{HBURST, HTRANS[0]};

    assign accept   = HSEL & HTRANS[1] & HREADY;
    assign xfer_err = (|HADDR[31:ADDR_WIDTH+2]) | (HSIZE > 3'b010)
                    | ((HSIZE == 3'b001) & HADDR[0])
                    | ((HSIZE == 3'b010) & (|HADDR[1:0]));

    always_comb begin
        case (HSIZE)
            3'b000:  strb = 4'b0001 << HADDR[1:0];
            3'b001:  strb = HADDR[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (xfer_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge HRESET) begin
        if (!HRESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            strb_q   <= '0;
            write_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (HREADY) begin
                // active_q marks an OKAY data phase; error transfers never reach the SRAM
                active_q <= accept & ~xfer_err;
                if (accept) begin
                    addr_q  <= HADDR[ADDR_WIDTH+1:2];
                    strb_q  <= strb;
                    write_q <= HWRITE;
                end
            end
        end
    end

    assign commit = HREADY & active_q & write_q;
    assign wmask  = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};

    always_ff @(posedge clk) begin
        if (commit) mem[addr_q] <= (mem[addr_q] & ~wmask) | (HWDATA & wmask);
    end

    always_comb begin
        HREADY = (state == ST_IDLE) | (state == ST_ERR2);
        HRESP  = {1'b0, (state == ST_ERR1) | (state == ST_ERR2)};
        HRDATA = (state == ST_IDLE && active_q && !write_q) ? mem[addr_q] : '0;
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one zero-wait and one two-wait instance
// share a pipelined AHB master; a reference memory predicts every data phase.
module tb_ahb_sram_slave;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hburst = '0;
    logic [2:0]  hsize = '0;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = '0;
    logic        hready0, hready1;
    logic [31:0] hrdata0, hrdata1;
    logic [1:0]  hresp0, hresp1;
    logic        hsel0, hsel1;
    logic        hready_b;
    logic [31:0] hrdata_b;
    logic [1:0]  hresp_b;

    int          sel = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    beat_t       beats[$];
    exp_t        sb[$];
    logic [31:0] mdl [0:1][0:1023];

    always #5 clk = ~clk;

    assign hsel0    = hsel & (sel == 0);
    assign hsel1    = hsel & (sel == 1);
    assign hready_b = (sel == 1) ? hready1 : hready0;
    assign hrdata_b = (sel == 1) ? hrdata1 : hrdata0;
    assign hresp_b  = (sel == 1) ? hresp1  : hresp0;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
        .HREADY(hready0), .HRDATA(hrdata0), .HRESP(hresp0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
        .HREADY(hready1), .HRDATA(hrdata1), .HRESP(hresp1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", tag, act, exp, sel, $time);
        else n_pass++;
    endtask

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
        return (a[31:12] != 0) || (s > 3'b010) || (s == 3'b001 && a[0]) || (s == 3'b010 && a[1:0] != 0);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] a, input logic [2:0] s);
        logic [3:0]  st;
        logic [31:0] m;
        case (s)
            3'b000:  st = 4'b0001 << a[1:0];
            3'b001:  st = a[1] ? 4'b1100 : 4'b0011;
            default: st = 4'b1111;
        endcase
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{st[b]}};
        return m;
    endfunction

    task automatic add(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                       input logic w, input logic [31:0] d);
        beat_t b;
        b.trans = t; b.addr = a; b.size = s; b.write = w; b.wdata = d;
        beats.push_back(b);
    endtask

    // Predict the response of a beat at the moment its address phase is accepted.
    task automatic push_exp(input beat_t b);
        exp_t        e;
        logic [31:0] m;
        int unsigned w;
        w       = int'(b.addr[11:2]);
        e.write = b.write;
        e.err   = is_err(b.addr, b.size);
        e.rdata = '0;
        if (!e.err) begin
            if (b.write) begin
                m = lane_mask(b.addr, b.size);
                mdl[sel][w] = (mdl[sel][w] & ~m) | (b.wdata & m);
            end else begin
                e.rdata = mdl[sel][w];
            end
        end
        sb.push_back(e);
    endtask

    // Pipelined master: entered and left #1 after a rising edge.
    task automatic run_bus();
        logic        dp_valid = 1'b0;
        logic [31:0] dp_wdata = '0;
        int unsigned idx = 0;
        int unsigned low = 0;
        int unsigned ws;
        exp_t        e;
        ws = (sel == 1) ? 2 : 0;
        while (idx < beats.size() || dp_valid) begin
            if (idx < beats.size()) begin
                hsel   = 1'b1;
                htrans = beats[idx].trans;
                haddr  = beats[idx].addr;
                hsize  = beats[idx].size;
                hwrite = beats[idx].write;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            hwdata = dp_wdata;
            @(negedge clk);
            if (!hready_b) begin
                low++;
                chk("hrdata_wait", hrdata_b, 32'd0);
                if (dp_valid) chk("hresp_wait", {30'd0, hresp_b}, sb[0].err ? 32'd1 : 32'd0);
                else          chk("idle_hready", {31'd0, hready_b}, 32'd1);
                if (low > ws + 1) begin
                    chk("hready_low_bound", low, ws + 1);
                    sb.delete();
                    beats.delete();
                    hsel = 1'b0; htrans = 2'b00;
                    @(posedge clk); #1;
                    return;
                end
            end else begin
                if (dp_valid) begin
                    e = sb.pop_front();
                    chk("wait_cycles", low, e.err ? 32'd1 : ws);
                    chk("hresp", {30'd0, hresp_b}, e.err ? 32'd1 : 32'd0);
                    chk("hrdata", hrdata_b, (e.err || e.write) ? 32'd0 : e.rdata);
                end else begin
                    chk("idle_resp", {30'd0, hresp_b}, 32'd0);
                end
                low      = 0;
                dp_valid = 1'b0;
                if (idx < beats.size()) begin
                    if (beats[idx].trans[1]) begin
                        push_exp(beats[idx]);
                        dp_valid = 1'b1;
                        dp_wdata = beats[idx].wdata;
                    end
                    idx++;
                end
            end
            @(posedge clk); #1;
        end
        hsel   = 1'b0;
        htrans = 2'b00;
        beats.delete();
    endtask

    task automatic common_seq();
        add(2'b10, 32'h10, 3'b010, 1'b1, 32'h1122_3344);
        add(2'b10, 32'h13, 3'b000, 1'b1, 32'hAA99_8877);
        add(2'b10, 32'h10, 3'b010, 1'b0, 32'h0);
        add(2'b10, 32'h12, 3'b001, 1'b1, 32'h5566_1234);
        add(2'b10, 32'h10, 3'b010, 1'b0, 32'h0);
        add(2'b10, 32'h1000, 3'b010, 1'b0, 32'h0);
        add(2'b10, 32'h10, 3'b011, 1'b1, 32'hFFFF_FFFF);
        add(2'b10, 32'h11, 3'b001, 1'b1, 32'hFFFF_FFFF);
        add(2'b10, 32'h12, 3'b010, 1'b1, 32'hFFFF_FFFF);
        add(2'b10, 32'h10, 3'b010, 1'b0, 32'h0);
        add(2'b10, 32'h20, 3'b010, 1'b1, 32'd1);
        add(2'b11, 32'h24, 3'b010, 1'b1, 32'd2);
        add(2'b01, 32'h28, 3'b010, 1'b1, 32'd0);
        add(2'b11, 32'h28, 3'b010, 1'b1, 32'd3);
        add(2'b11, 32'h2C, 3'b010, 1'b1, 32'd4);
        add(2'b10, 32'h28, 3'b010, 1'b0, 32'h0);
        add(2'b11, 32'h2C, 3'b010, 1'b0, 32'h0);
        add(2'b11, 32'h20, 3'b010, 1'b0, 32'h0);
        add(2'b11, 32'h24, 3'b010, 1'b0, 32'h0);
    endtask

    initial begin
        #3;
        chk("rst_hready0", {31'd0, hready0}, 32'd1);
        chk("rst_hresp0",  {30'd0, hresp0},  32'd0);
        chk("rst_hrdata0", hrdata0,          32'd0);
        chk("rst_hready1", {31'd0, hready1}, 32'd1);
        chk("rst_hrdata1", hrdata1,          32'd0);
        @(posedge clk); #1;
        hreset = 1'b1;
        @(posedge clk); #1;

        sel = 0;
        add(2'b10, 32'h10, 3'b010, 1'b1, 32'hDEAD_BEEF);
        add(2'b10, 32'h10, 3'b010, 1'b0, 32'h0);
        common_seq();
        run_bus();

        sel = 1;
        add(2'b10, 32'h0, 3'b010, 1'b1, 32'hCAFE_F00D);
        add(2'b10, 32'h0, 3'b010, 1'b0, 32'h0);
        common_seq();
        add(2'b10, 32'h30, 3'b010, 1'b1, 32'h1234_5678);
        add(2'b10, 32'h30, 3'b010, 1'b0, 32'h0);
        run_bus();

        // Reset in the middle of a write's wait states must drop the write.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hsize = 3'b010; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBAD0_BAD0;
        chk("wait_before_rst", {31'd0, hready1}, 32'd0);
        #2 hreset = 1'b0;
        #1;
        chk("rst_async_hready", {31'd0, hready1}, 32'd1);
        chk("rst_async_hresp",  {30'd0, hresp1},  32'd0);
        chk("rst_async_hrdata", hrdata1,          32'd0);
        @(posedge clk); #1;
        hreset = 1'b1;
        add(2'b10, 32'h30, 3'b010, 1'b0, 32'h0);
        run_bus();

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
